// File: rtl/store_write_buffer.sv
// Store write buffer: circular FIFO of {address, data} stores draining to a
// memory bus, with combinational store-to-load forwarding from buffered entries.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [31:0]   DataAdr,
    input  logic [31:0]   WriteData,
    input  logic [31:0]   ReadAdr,
    output logic          Stall,
    output logic          BusValid,
    output logic [31:0]   BusAdr,
    output logic [31:0]   BusData,
    input  logic          BusReady,
    output logic          FwdHit,
    output logic [31:0]   FwdData,
    output logic [CW-1:0] Count,
    output logic          Overflow,
    output logic          Misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE_C = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO_C = CW'(1'b0);
    localparam logic [CW-1:0] CNT_FULL_C = CW'(DEPTH);

    logic [31:0]   adrMem_r  [DEPTH];
    logic [31:0]   dataMem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;
    logic          misalign_r;

    logic          full_s;
    logic          aligned_s;
    logic          busValid_s;
    logic          enq_s;
    logic          deq_s;
    logic          fwdHit_s;
    logic [31:0]   fwdData_s;
    logic [AW-1:0] fwdIdx_s;
    logic          unusedReadLow_s;

    assign full_s     = (count_r == CNT_FULL_C);
    assign aligned_s  = (DataAdr[1:0] == 2'b00);
    assign busValid_s = (count_r != CNT_ZERO_C);
    assign enq_s      = MemWrite & aligned_s & ~full_s;
    assign deq_s      = busValid_s & BusReady;

    // Forwarding matches on word address only; the byte offset is irrelevant.
    assign unusedReadLow_s = ^ReadAdr[1:0];

    // Entry storage: written at tail on enqueue, never cleared.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            adrMem_r[tail_r]  <= DataAdr;
            dataMem_r[tail_r] <= WriteData;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + PTR_ONE_C;
            end
            if (deq_s) begin
                head_r <= head_r + PTR_ONE_C;
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags; a misaligned store never counts as an overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            if (MemWrite && aligned_s && full_s) begin
                overflow_r <= 1'b1;
            end
            if (MemWrite && !aligned_s) begin
                misalign_r <= 1'b1;
            end
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        fwdHit_s  = 1'b0;
        fwdData_s = 32'h0000_0000;
        fwdIdx_s  = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            fwdIdx_s = head_r + AW'(i);
            if ((CW'(i) < count_r) && (adrMem_r[fwdIdx_s][31:2] == ReadAdr[31:2])) begin
                fwdHit_s  = 1'b1;
                fwdData_s = dataMem_r[fwdIdx_s];
            end else begin
                fwdHit_s  = fwdHit_s;
                fwdData_s = fwdData_s;
            end
        end
    end

    assign Stall    = full_s;
    assign BusValid = busValid_s;
    assign BusAdr   = busValid_s ? adrMem_r[head_r]  : 32'h0000_0000;
    assign BusData  = busValid_s ? dataMem_r[head_r] : 32'h0000_0000;
    assign FwdHit   = fwdHit_s;
    assign FwdData  = fwdData_s;
    assign Count    = count_r;
    assign Overflow = overflow_r;
    assign Misalign = misalign_r;

endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of buffered stores; power of two, >= 2.
REQ-002 Parameter CW, default 3: width of Count; equals log2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 clears state immediately, independent of clk.
REQ-005 MemWrite  input  1  processor store request this cycle.
REQ-006 DataAdr  input  32  processor store byte address.
REQ-007 WriteData  input  32  processor store data.
REQ-008 ReadAdr  input  32  processor load address, used for store-to-load forwarding.
REQ-009 Stall  output  1  buffer full; processor must hold the store.
REQ-010 BusValid  output  1  head entry presented to the memory bus.
REQ-011 BusAdr  output  32  head entry address.
REQ-012 BusData  output  32  head entry data.
REQ-013 BusReady  input  1  memory accepts the head entry this cycle.
REQ-014 FwdHit  output  1  ReadAdr matches a buffered store.
REQ-015 FwdData  output  32  data of the youngest matching store; 0 when FwdHit=0.
REQ-016 Count  output  CW  number of valid entries, 0..DEPTH.
REQ-017 Overflow  output  1  sticky flag: a store was dropped.
REQ-018 Misalign  output  1  sticky flag: a store with DataAdr[1:0]!=0 was rejected.

Function
REQ-019 Storage: circular FIFO of DEPTH {address, data} entries, head and tail pointers wrapping modulo DEPTH.
REQ-020 Enqueue occurs on a rising edge when MemWrite=1, Count<DEPTH and DataAdr[1:0]=0; the entry is written at tail and tail advances by 1.
REQ-021 Dequeue occurs on a rising edge when BusValid=1 and BusReady=1; head advances by 1.
REQ-022 Simultaneous enqueue and dequeue with 0<Count<DEPTH: both occur, Count unchanged.
REQ-023 When Count=DEPTH, MemWrite=1 does not enqueue even if a dequeue occurs in the same cycle; the store is dropped, Overflow is set, and Count decreases by the dequeue only.
REQ-024 MemWrite=1 with DataAdr[1:0]!=0 does not enqueue and sets Misalign; this applies in every fill state, and Overflow is not set.
REQ-025 Stall is combinational: Stall=1 iff Count=DEPTH.
REQ-026 BusValid=1 iff Count>0; BusAdr and BusData show the head entry and are 0 when Count=0.
REQ-027 While BusValid=1 and BusReady=0, BusAdr and BusData remain stable across cycles.
REQ-028 Latency: a store enqueued into an empty buffer at edge k appears with BusValid=1 in the cycle following edge k; there is no same-cycle bypass.
REQ-029 Forwarding is combinational and compares ReadAdr[31:2] against all valid entries.
REQ-030 FwdData comes from the matching entry closest to tail (youngest).
REQ-031 An entry being dequeued in the current cycle still participates in forwarding.
REQ-032 A store being enqueued in the current cycle does not participate in forwarding.
REQ-033 Overflow and Misalign, once set, stay 1 until reset.
REQ-034 BusReady=1 while BusValid=0 has no effect.

Reset
REQ-035 While reset=0: Count=0, head=0, tail=0, Overflow=0, Misalign=0, BusValid=0, BusAdr=0, BusData=0, Stall=0, FwdHit=0, FwdData=0.
REQ-036 Reset asserted mid-operation discards all buffered entries asynchronously; no bus transfer completes after assertion.
REQ-037 Entry storage contents need not be cleared; only the valid state is reset.

Verification
REQ-038 Basic store: from reset, one cycle of MemWrite=1, DataAdr=0x64, WriteData=7, with BusReady=0 -> Count=1, BusValid=1, BusAdr=0x64, BusData=7, held stable; then BusReady=1 for one cycle -> Count=0, BusValid=0.
REQ-039 Fill and overflow with DEPTH=4 and BusReady=0: stores to 0x60, 0x64, 0x68, 0x6C -> Stall=1, Count=4; a fifth store to 0x70 -> dropped, Overflow=1, Count=4; draining then yields addresses 0x60, 0x64, 0x68, 0x6C in order.
REQ-040 Forwarding: with BusReady=0, store 0x60<-3, then 0x60<-9, then ReadAdr=0x60 -> FwdHit=1, FwdData=9; with ReadAdr=0x64 -> FwdHit=0, FwdData=0.
REQ-041 Concurrent enqueue/dequeue and wrap-around: with Count=2 and BusReady=1, MemWrite=1 every cycle for 8 cycles -> Count stays 2, bus order equals issue order, and both pointers wrap past DEPTH.
REQ-042 Misaligned store: MemWrite=1, DataAdr=0x66 -> Count unchanged, Misalign=1, Overflow=0.
REQ-043 Asynchronous reset: with Count=3, drive reset=0 between clock edges -> Count=0 and BusValid=0 before the next rising edge; after reset=1, the first new store appears at BusAdr.
